// File: rtl/sata_prim_pkg.sv
// Purpose: shared SATA primitive definitions for the RX decoder and, later,
//   the TX mux and link layer. Holds 32-bit primitive encodings, K28.3/K28.5
//   byte values, the primitive code enum and the RX decoder FSM state type.
// Ports: none (package).
package sata_prim_pkg;

  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;

  localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;
  localparam logic [31:0] CONT_DW  = 32'h9999AA7C;
  localparam logic [31:0] SOF_DW   = 32'h3737B57C;
  localparam logic [31:0] EOF_DW   = 32'hD5D5B57C;
  localparam logic [31:0] X_RDY_DW = 32'h5757B57C;
  localparam logic [31:0] R_RDY_DW = 32'h4A4A957C;
  localparam logic [31:0] R_IP_DW  = 32'h5555B57C;
  localparam logic [31:0] R_OK_DW  = 32'h3535B57C;
  localparam logic [31:0] R_ERR_DW = 32'h5656B57C;
  localparam logic [31:0] WTRM_DW  = 32'h5858B57C;
  localparam logic [31:0] HOLD_DW  = 32'hD5D5AA7C;
  localparam logic [31:0] HOLDA_DW = 32'h9595AA7C;

  typedef enum logic [3:0] {
    PRIM_NONE  = 4'd0,
    PRIM_SYNC  = 4'd1,
    PRIM_SOF   = 4'd2,
    PRIM_EOF   = 4'd3,
    PRIM_X_RDY = 4'd4,
    PRIM_R_RDY = 4'd5,
    PRIM_R_IP  = 4'd6,
    PRIM_R_OK  = 4'd7,
    PRIM_R_ERR = 4'd8,
    PRIM_WTRM  = 4'd9,
    PRIM_HOLD  = 4'd10,
    PRIM_HOLDA = 4'd11,
    PRIM_ALIGN = 4'd12
  } prim_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_NORMAL   = 2'd1,
    ST_CONT_ACT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sata_prim_match.sv
// Purpose: combinational classifier for one received dword.
// Ports:
//   dword_i     in  32  received dword
//   charisk_i   in  4   K-flags per byte, byte0 = [0]
//   is_data_o   out 1   plain data dword (no K-flags)
//   is_prim_o   out 1   recognised primitive (includes ALIGN and CONT)
//   is_cont_o   out 1   recognised primitive is CONT
//   prim_code_o out 4   prim_code_t of the primitive (PRIM_NONE for CONT)
//   code_err_o  out 1   illegal K pattern or unknown primitive
module sata_prim_match
  import sata_prim_pkg::*;
(
  input  logic [31:0] dword_i,
  input  logic [3:0]  charisk_i,
  output logic        is_data_o,
  output logic        is_prim_o,
  output logic        is_cont_o,
  output logic [3:0]  prim_code_o,
  output logic        code_err_o
);

  always_comb begin
    is_data_o   = 1'b0;
    is_prim_o   = 1'b0;
    is_cont_o   = 1'b0;
    prim_code_o = PRIM_NONE;
    code_err_o  = 1'b0;
    if (charisk_i == 4'b0000) begin
      is_data_o = 1'b1;
    end else if (charisk_i == 4'b0001 &&
                 (dword_i[7:0] == K28_3 || dword_i[7:0] == K28_5)) begin
      is_prim_o = 1'b1;
      case (dword_i)
        ALIGN_DW: prim_code_o = PRIM_ALIGN;
        CONT_DW:  is_cont_o   = 1'b1;
        SYNC_DW:  prim_code_o = PRIM_SYNC;
        SOF_DW:   prim_code_o = PRIM_SOF;
        EOF_DW:   prim_code_o = PRIM_EOF;
        X_RDY_DW: prim_code_o = PRIM_X_RDY;
        R_RDY_DW: prim_code_o = PRIM_R_RDY;
        R_IP_DW:  prim_code_o = PRIM_R_IP;
        R_OK_DW:  prim_code_o = PRIM_R_OK;
        R_ERR_DW: prim_code_o = PRIM_R_ERR;
        WTRM_DW:  prim_code_o = PRIM_WTRM;
        HOLD_DW:  prim_code_o = PRIM_HOLD;
        HOLDA_DW: prim_code_o = PRIM_HOLDA;
        default: begin
          is_prim_o  = 1'b0;
          code_err_o = 1'b1;
        end
      endcase
    end else begin
      code_err_o = 1'b1;
    end
  end

endmodule

// File: rtl/sata_rx_prim_decoder.sv
// Purpose: RX primitive decoder between the OOB/link-init block and the link
//   layer FSM. Splits data from primitives, drops ALIGN, expands CONT by
//   repeating the last primitive, and registers a clean output stream
//   (1 clk latency, no backpressure).
// Optional feature macro: RX_PRIM_STATS_EN enables the saturating cont_cnt /
//   err_cnt statistics counters; without it both ports are tied to 0.
// Ports:
//   clk, reset (sync, active-low), linkup (low = held idle)
//   rx_datain[31:0], rx_charisk_in[3:0]  received dword and K-flags
//   data_out[31:0], data_valid           data stream
//   prim_code[3:0], prim_valid           primitive stream (prim_code_t)
//   cont_active                          CONT expansion in progress
//   code_err, cont_err                   1-cycle error pulses
//   cont_cnt, err_cnt [STATS_W-1:0]      statistics
module sata_rx_prim_decoder
  import sata_prim_pkg::*;
#(
  parameter int DROP_ALIGN = 1,
  parameter int STATS_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               linkup,
  input  logic [31:0]        rx_datain,
  input  logic [3:0]         rx_charisk_in,
  output logic [31:0]        data_out,
  output logic               data_valid,
  output logic [3:0]         prim_code,
  output logic               prim_valid,
  output logic               cont_active,
  output logic               code_err,
  output logic               cont_err,
  output logic [STATS_W-1:0] cont_cnt,
  output logic [STATS_W-1:0] err_cnt
);

  logic        m_is_data, m_is_prim, m_is_cont, m_code_err;
  logic [3:0]  m_code;
  logic        m_is_align;

  sata_prim_match u_match (
    .dword_i     (rx_datain),
    .charisk_i   (rx_charisk_in),
    .is_data_o   (m_is_data),
    .is_prim_o   (m_is_prim),
    .is_cont_o   (m_is_cont),
    .prim_code_o (m_code),
    .code_err_o  (m_code_err)
  );

  assign m_is_align = m_is_prim && (m_code == PRIM_ALIGN);

  rx_state_t   state_q, state_d;
  prim_code_t  last_q, last_d;
  logic [31:0] data_q, data_d;
  logic        dv_q, dv_d, pv_q, pv_d, ca_q, ca_d, ce_q, ce_d, cte_q, cte_d;
  logic [3:0]  pc_q, pc_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= PRIM_NONE;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pv_q    <= 1'b0;
      pc_q    <= PRIM_NONE;
      ca_q    <= 1'b0;
      ce_q    <= 1'b0;
      cte_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pv_q    <= pv_d;
      pc_q    <= pc_d;
      ca_q    <= ca_d;
      ce_q    <= ce_d;
      cte_q   <= cte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = '0;
    dv_d    = 1'b0;
    pv_d    = 1'b0;
    pc_d    = PRIM_NONE;
    ca_d    = 1'b0;
    ce_d    = 1'b0;
    cte_d   = 1'b0;
    if (!linkup) begin
      state_d = ST_IDLE;
      last_d  = PRIM_NONE;
    end else begin
      case (state_q)
        // IDLE decodes the first linkup dword like NORMAL so nothing is lost
        // on the rising edge of linkup (last_prim is already NONE there).
        ST_IDLE, ST_NORMAL: begin
          state_d = ST_NORMAL;
          if (m_code_err) begin
            ce_d = 1'b1;
          end else if (m_is_data) begin
            dv_d   = 1'b1;
            data_d = rx_datain;
          end else if (m_is_align) begin
            if (DROP_ALIGN == 0) begin
              pv_d = 1'b1;
              pc_d = PRIM_ALIGN;
            end
          end else if (m_is_cont) begin
            if (last_q == PRIM_NONE) begin
              cte_d = 1'b1;
            end else begin
              state_d = ST_CONT_ACT;
              pv_d    = 1'b1;
              pc_d    = last_q;
              ca_d    = 1'b1;
            end
          end else begin
            pv_d   = 1'b1;
            pc_d   = m_code;
            last_d = prim_code_t'(m_code);
          end
        end
        ST_CONT_ACT: begin
          // Repeat last_prim every cycle; only a real primitive ends expansion.
          pv_d = 1'b1;
          pc_d = last_q;
          ca_d = 1'b1;
          if (m_code_err) begin
            ce_d = 1'b1;
          end else if (m_is_align) begin
            if (DROP_ALIGN == 0) pc_d = PRIM_ALIGN;
          end else if (m_is_prim && !m_is_cont) begin
            pc_d    = m_code;
            last_d  = prim_code_t'(m_code);
            ca_d    = 1'b0;
            state_d = ST_NORMAL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign prim_code   = pc_q;
  assign prim_valid  = pv_q;
  assign cont_active = ca_q;
  assign code_err    = ce_q;
  assign cont_err    = cte_q;

`ifdef RX_PRIM_STATS_EN
  logic [STATS_W-1:0] cont_cnt_q, err_cnt_q;
  logic               cont_entry;

  assign cont_entry = (state_q != ST_CONT_ACT) && (state_d == ST_CONT_ACT);

  always_ff @(posedge clk) begin
    if (!reset || !linkup) begin
      cont_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (cont_entry && !(&cont_cnt_q)) cont_cnt_q <= cont_cnt_q + 1'b1;
      if ((ce_d || cte_d) && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign cont_cnt = cont_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign cont_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
module tb_sata_rx_prim_decoder;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset, linkup;
  logic [31:0]   rx_datain;
  logic [3:0]    rx_charisk_in;
  logic [31:0]   data_out;
  logic          data_valid, prim_valid, cont_active, code_err, cont_err;
  logic [3:0]    prim_code;
  logic [SW-1:0] cont_cnt, err_cnt;

  sata_rx_prim_decoder #(.DROP_ALIGN(1), .STATS_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .linkup        (linkup),
    .rx_datain     (rx_datain),
    .rx_charisk_in (rx_charisk_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .prim_code     (prim_code),
    .prim_valid    (prim_valid),
    .cont_active   (cont_active),
    .code_err      (code_err),
    .cont_err      (cont_err),
    .cont_cnt      (cont_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit            idle;
    bit            dv;
    logic [31:0]   data;
    bit            pv;
    logic [3:0]    pc;
    bit            ca;
    bit            ce;
    bit            cte;
    logic [SW-1:0] cc;
    logic [SW-1:0] ec;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Index = primitive code; 13 = CONT. Entry 0 unused.
  logic [31:0] ptab [14] = '{32'h0, 32'hB5B5957C, 32'h3737B57C, 32'hD5D5B57C,
    32'h5757B57C, 32'h4A4A957C, 32'h5555B57C, 32'h3535B57C, 32'h5656B57C,
    32'h5858B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h7B4A4ABC, 32'h9999AA7C};

  localparam int C_ERR = -1, C_DATA = -2, C_ALIGN = 12, C_CONT = 13;

  // Reference model state: are we repeating, and which primitive.
  bit            m_rep;
  int            m_last;
  logic [SW-1:0] m_cc, m_ec;

  function automatic int classify(input logic [31:0] dw, input logic [3:0] k);
    if (k == 4'b0000) return C_DATA;
    if (k != 4'b0001) return C_ERR;
    for (int i = 1; i < 14; i++) if (ptab[i] == dw) return i;
    return C_ERR;
  endfunction

  function automatic exp_t model(input bit rstn, input bit lk,
                                 input logic [31:0] dw, input logic [3:0] k);
    exp_t e;
    int   c;
    e = '0;
    if (!rstn || !lk) begin
      m_rep = 0; m_last = 0; m_cc = '0; m_ec = '0;
      e.idle = 1;
      return e;
    end
    c = classify(dw, k);
    if (m_rep) begin
      e.pv = 1; e.pc = 4'(m_last); e.ca = 1;
      if (c == C_ERR) e.ce = 1;
      else if (c >= 1 && c <= 11) begin
        e.pc = 4'(c); m_last = c; m_rep = 0; e.ca = 0;
      end
    end else begin
      if (c == C_ERR) e.ce = 1;
      else if (c == C_DATA) begin e.dv = 1; e.data = dw; end
      else if (c == C_CONT) begin
        if (m_last == 0) e.cte = 1;
        else begin
          m_rep = 1; e.pv = 1; e.pc = 4'(m_last); e.ca = 1;
`ifdef RX_PRIM_STATS_EN
          if (m_cc != '1) m_cc = m_cc + 1'b1;
`endif
        end
      end else if (c != C_ALIGN) begin
        e.pv = 1; e.pc = 4'(c); m_last = c;
      end
    end
`ifdef RX_PRIM_STATS_EN
    if ((e.ce || e.cte) && m_ec != '1) m_ec = m_ec + 1'b1;
`endif
    e.cc = m_cc;
    e.ec = m_ec;
    return e;
  endfunction

  task automatic drive(input bit r, input bit lk, input logic [31:0] dw,
                       input logic [3:0] k);
    @(negedge clk);
    reset = r; linkup = lk; rx_datain = dw; rx_charisk_in = k;
    expq.push_back(model(r, lk, dw, k));
  endtask

  task automatic prim(input int code);
    drive(1, 1, ptab[code], 4'b0001);
  endtask

  task automatic dat(input logic [31:0] dw);
    drive(1, 1, dw, 4'b0000);
  endtask

  // Monitor: one output per input cycle, 1 clk later.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        ok = (data_valid == e.dv) && (prim_valid == e.pv) &&
             (cont_active == e.ca) && (code_err == e.ce) && (cont_err == e.cte) &&
             (cont_cnt == e.cc) && (err_cnt == e.ec) &&
             (!e.dv || data_out == e.data) &&
             (!(e.pv || e.idle) || prim_code == e.pc) &&
             (!e.idle || data_out == 32'h0);
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL out@%0t: got dv=%0b d=%h pv=%0b pc=%0d ca=%0b ce=%0b cte=%0b cc=%0d ec=%0d; required dv=%0b d=%h pv=%0b pc=%0d ca=%0b ce=%0b cte=%0b cc=%0d ec=%0d idle=%0b",
                   $time, data_valid, data_out, prim_valid, prim_code, cont_active,
                   code_err, cont_err, cont_cnt, err_cnt, e.dv, e.data, e.pv, e.pc,
                   e.ca, e.ce, e.cte, e.cc, e.ec, e.idle);
        end
      end
    end
  end

  initial begin
    int r;
    logic [3:0] bk;
    reset = 0; linkup = 0; rx_datain = '0; rx_charisk_in = '0;
    m_rep = 0; m_last = 0; m_cc = '0; m_ec = '0;
    drive(0, 0, 32'h0, 4'h0);
    drive(0, 1, 32'h0, 4'h0);
    drive(1, 0, 32'h0, 4'h0);

    // Reset in the middle of CONT expansion.
    prim(10); prim(13); dat(32'hDEADBEEF);
    drive(0, 1, 32'hCAFEF00D, 4'h0);
    drive(1, 1, 32'h11111111, 4'h0);
    drive(1, 0, 32'h0, 4'h0);

    // CONT right after linkup rise, before any primitive.
    prim(13);
    // SYNC SYNC CONT junk x5 R_RDY
    prim(1); prim(1); prim(13);
    for (int i = 0; i < 5; i++) dat($urandom);
    prim(5);
    // SOF data ALIGN data EOF
    prim(2); dat(32'h12345678); prim(12); dat(32'h9ABCDEF0); prim(3);
    // Illegal K patterns and unknown primitive.
    drive(1, 1, 32'hA5A5A5A5, 4'b0011);
    drive(1, 1, 32'h1234567C, 4'b0001);
    drive(1, 1, 32'hB5B5957C, 4'b1000);
    // HOLD CONT ALIGN junk HOLDA, error during expansion, then linkup drop.
    prim(10); prim(13); prim(12); dat(32'h0BADF00D); prim(11);
    prim(9); prim(13); drive(1, 1, 32'h1234567C, 4'b0001); prim(13); prim(7);
    drive(1, 0, 32'h0, 4'h0);
    prim(13); prim(6);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      prim(int'($urandom_range(1, 13)));
      else if (r < 55) prim(13);
      else if (r < 82) dat($urandom);
      else if (r < 88) begin
        bk = 4'($urandom_range(2, 15));
        drive(1, 1, $urandom, bk);
      end
      else if (r < 93) drive(1, 1, {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), 8'h7C}, 4'b0001);
      else if (r < 98) drive(1, 0, $urandom, 4'($urandom));
      else             drive(0, 1, $urandom, 4'($urandom));
    end

`ifdef RX_PRIM_STATS_EN
    // Saturate the error counter.
    drive(1, 0, 32'h0, 4'h0);
    for (int n = 0; n < (1 << SW) + 5; n++) drive(1, 1, 32'h1234567C, 4'b0001);
`endif

    drive(1, 1, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outputs left unchecked, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
